// File: rtl/shift_pattern_checker.sv
`default_nettype none
// ============================================================================
//  Module   : shift_pattern_checker
//  Purpose  : Decodes a rotating one-hot code, tracks lock on the rotate-left
//             sequence, and flags/counts sequence errors and full laps.
//  Revision : 1.0  initial release
// ============================================================================
module shift_pattern_checker #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned IDX_W    = 3,
    parameter int unsigned LOCK_CNT = 3,
    parameter int unsigned ERR_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [WIDTH-1:0]   count,
    output logic [IDX_W-1:0]   pos,
    output logic               locked,
    output logic               err,
    output logic [ERR_W-1:0]   err_count,
    output logic               lap
);

    localparam int unsigned         c_GOOD_W    = $clog2(LOCK_CNT + 1);
    localparam logic [c_GOOD_W-1:0] c_LOCK_LAST = c_GOOD_W'(LOCK_CNT - 1);
    localparam logic [WIDTH-1:0]    c_ONE       = WIDTH'(1);
    localparam logic [ERR_W-1:0]    c_ERR_MAX   = '1;

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t              r_state;
    logic [WIDTH-1:0]    r_prev;
    logic                r_prev_valid;
    logic [c_GOOD_W-1:0] r_good;
    logic [IDX_W-1:0]    r_pos;
    logic                r_err;
    logic [ERR_W-1:0]    r_err_count;
    logic                r_lap;

    logic                w_legal;
    logic                w_match;
    logic [WIDTH-1:0]    w_expected;
    logic [IDX_W-1:0]    w_pos;

    // x & (x-1) clears the lowest set bit, so a nonzero result means >1 bit set
    assign w_legal    = (count != '0) && ((count & (count - c_ONE)) == '0);
    assign w_expected = {r_prev[WIDTH-2:0], r_prev[WIDTH-1]};
    assign w_match    = w_legal && r_prev_valid && (count == w_expected);

    always_comb begin
        w_pos = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (count[i]) begin
                w_pos = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_SEARCH;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_good       <= '0;
            r_pos        <= '0;
            r_err        <= 1'b0;
            r_err_count  <= '0;
            r_lap        <= 1'b0;
        end else begin
            r_err <= 1'b0;
            r_lap <= 1'b0;
            if (en) begin
                case (r_state)
                    ST_SEARCH: begin
                        if (w_legal) begin
                            r_prev       <= count;
                            r_prev_valid <= 1'b1;
                            r_pos        <= w_pos;
                            if (w_match) begin
                                if (r_good == c_LOCK_LAST) begin
                                    r_state <= ST_LOCKED;
                                    r_good  <= '0;
                                end else begin
                                    r_good <= r_good + 1'b1;
                                end
                            end else begin
                                r_good <= '0;
                            end
                        end else begin
                            r_good       <= '0;
                            r_prev_valid <= 1'b0;
                        end
                    end
                    ST_LOCKED: begin
                        if (w_match) begin
                            r_prev <= count;
                            r_pos  <= w_pos;
                            // prev is one-hot here, so its MSB alone identifies the wrap
                            r_lap  <= r_prev[WIDTH-1];
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= ST_SEARCH;
                            r_good  <= '0;
                            if (r_err_count != c_ERR_MAX) begin
                                r_err_count <= r_err_count + 1'b1;
                            end
                            if (w_legal) begin
                                r_prev       <= count;
                                r_prev_valid <= 1'b1;
                                r_pos        <= w_pos;
                            end else begin
                                r_prev_valid <= 1'b0;
                            end
                        end
                    end
                    default: r_state <= ST_SEARCH;
                endcase
            end
        end
    end

    assign pos       = r_pos;
    assign locked    = (r_state == ST_LOCKED);
    assign err       = r_err;
    assign err_count = r_err_count;
    assign lap       = r_lap;

endmodule
`default_nettype wire

// File: tb/tb_shift_pattern_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_pattern_checker
//  Purpose  : Directed self-checking bench for shift_pattern_checker.
//  Revision : 1.0  initial release
// ============================================================================
module tb_shift_pattern_checker;

    logic       clk;
    logic       reset;
    logic       en;
    logic [7:0] count;
    logic [2:0] pos;
    logic       locked;
    logic       err;
    logic [7:0] err_count;
    logic       lap;

    int n_cmp;
    int n_bad;

    shift_pattern_checker #(
        .WIDTH    (8),
        .IDX_W    (3),
        .LOCK_CNT (3),
        .ERR_W    (8)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .count     (count),
        .pos       (pos),
        .locked    (locked),
        .err       (err),
        .err_count (err_count),
        .lap       (lap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int e_pos, input int e_locked,
                              input int e_err, input int e_cnt, input int e_lap);
        check({tag, ".pos"},       int'(pos),       e_pos);
        check({tag, ".locked"},    int'(locked),    e_locked);
        check({tag, ".err"},       int'(err),       e_err);
        check({tag, ".err_count"}, int'(err_count), e_cnt);
        check({tag, ".lap"},       int'(lap),       e_lap);
    endtask

    task automatic apply(input logic e, input logic [7:0] c);
        en    = e;
        count = c;
        @(posedge clk);
        #1;
    endtask

    int exp_cnt;

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        reset   = 1'b1;
        en      = 1'b0;
        count   = 8'h00;
        apply(1'b1, 8'h01);
        expect_out("reset", 0, 0, 0, 0, 0);
        reset = 1'b0;

        // Clean run 01..80,01,02: lock after the 4th word, lap on 80->01
        for (int k = 0; k < 10; k++) begin
            apply(1'b1, 8'(1 << (k % 8)));
            expect_out($sformatf("clean%0d", k), k % 8, (k >= 3) ? 1 : 0, 0, 0,
                       (k == 8) ? 1 : 0);
        end

        apply(1'b1, 8'h04);
        expect_out("pre_jump04", 2, 1, 0, 0, 0);
        apply(1'b1, 8'h08);
        expect_out("pre_jump08", 3, 1, 0, 0, 0);
        apply(1'b1, 8'h01);
        expect_out("jump", 0, 0, 1, 1, 0);
        apply(1'b1, 8'h02);
        expect_out("relock02", 1, 0, 0, 1, 0);
        apply(1'b1, 8'h04);
        expect_out("relock04", 2, 0, 0, 1, 0);
        apply(1'b1, 8'h08);
        expect_out("relock08", 3, 1, 0, 1, 0);

        // Illegal words while locked: only the first one is an error
        apply(1'b1, 8'h00);
        expect_out("illegal00", 3, 0, 1, 2, 0);
        apply(1'b1, 8'h03);
        expect_out("illegal03", 3, 0, 0, 2, 0);

        // Relock across the wrap: no lap while still searching
        apply(1'b1, 8'h20);
        expect_out("ref20", 5, 0, 0, 2, 0);
        apply(1'b1, 8'h40);
        expect_out("srch40", 6, 0, 0, 2, 0);
        apply(1'b1, 8'h80);
        expect_out("srch80", 7, 0, 0, 2, 0);
        apply(1'b1, 8'h01);
        expect_out("lock01", 0, 1, 0, 2, 0);
        apply(1'b1, 8'h02);
        expect_out("lk02", 1, 1, 0, 2, 0);
        apply(1'b1, 8'h04);
        expect_out("lk04", 2, 1, 0, 2, 0);

        // Enable gating with garbage on the bus
        for (int k = 0; k < 5; k++) begin
            apply(1'b0, 8'hFF);
            expect_out($sformatf("gate%0d", k), 2, 1, 0, 2, 0);
        end
        apply(1'b1, 8'h08);
        expect_out("ungate08", 3, 1, 0, 2, 0);

        // Saturation: 300 error/relock cycles
        exp_cnt = 2;
        for (int k = 0; k < 300; k++) begin
            apply(1'b1, 8'h01);
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            check($sformatf("sat_err%0d", k), int'(err), 1);
            check($sformatf("sat_cnt%0d", k), int'(err_count), exp_cnt);
            apply(1'b1, 8'h02);
            apply(1'b1, 8'h04);
            apply(1'b1, 8'h08);
        end
        expect_out("sat_end", 3, 1, 0, 255, 0);

        // Reset wins over an en=1 mismatching word while locked
        reset = 1'b1;
        apply(1'b1, 8'h01);
        expect_out("rst_prio", 0, 0, 0, 0, 0);
        reset = 1'b0;
        apply(1'b1, 8'h02);
        expect_out("post_rst", 1, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_pattern_checker.md
Name: shift_pattern_checker

Overview:
- Receive-side decoder/checker for the 8-bit walking-one code produced by the team's shift counter.
- Each accepted cycle it:
  - decodes the one-hot word to a binary bit position;
  - verifies that the word is the rotate-left of the previous word;
  - declares lock after a run of correct transitions;
  - flags and counts sequence errors, and pulses once per full lap.
- Sits directly on the counter's count bus in the same clock domain, as a self-checking monitor.

Parameters:
- WIDTH, 8, code width in bits; the expected sequence is a one-hot rotating left, ...->8'b1000_0000->8'b0000_0001->...
- IDX_W, 3, width of the position output; equals clog2(WIDTH).
- LOCK_CNT, 3, number of consecutive correct transitions required to enter LOCKED.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  sample enable; count is examined only on edges where en=1.
- count  input  WIDTH  code word from the shift counter.
- pos  output  IDX_W  index of the set bit in the last accepted legal word.
- locked  output  1  high while the FSM is in LOCKED.
- err  output  1  one-cycle pulse on a sequence error while LOCKED.
- err_count  output  ERR_W  number of errors since reset, saturating.
- lap  output  1  one-cycle pulse when LOCKED and the sequence wraps 8'b1000_0000->8'b0000_0001.

Behaviour:
- Clock and reset:
  - Single clock; reset is synchronous and active-high.
  - Reset dominates en.
  - Reset values: pos=0, locked=0, err=0, err_count=0, lap=0.
  - Internal reset values: prev=0, prev_valid=0, good=0, state=SEARCH.
- Latency: all outputs are registered. A word sampled on edge N is reflected in outputs after edge N.
- Legal word: exactly one bit set. All-zero and multi-bit words are illegal.
- Expected word: rotl(prev,1), where bit WIDTH-1 wraps to bit 0.
- en=0:
  - All state, pos, locked and err_count hold.
  - err and lap are 0.
- FSM SEARCH (locked=0), on an en=1 edge:
  - Legal word and prev_valid and word==rotl(prev): good<=good+1. If good+1==LOCK_CNT, go to LOCKED and clear good.
  - Legal word otherwise: good<=0. The word becomes the new reference.
  - Illegal word: good<=0, prev_valid<=0.
  - In all cases a legal word loads prev, sets prev_valid=1 and updates pos.
  - An illegal word leaves pos unchanged.
  - err never asserts in SEARCH.
- FSM LOCKED (locked=1), on an en=1 edge:
  - word==rotl(prev):
    - Update prev and pos; stay LOCKED.
    - lap=1 if prev was 8'b1000_0000.
  - Mismatch or illegal word:
    - err=1 for one cycle.
    - err_count<=err_count+1, saturating at all-ones.
    - Go to SEARCH with good=0.
    - A legal mismatching word is loaded as the new reference (prev_valid=1, pos updated).
    - An illegal word clears prev_valid; pos holds.
- Lock timing: from reset, the sequence 01,02,04,08 on consecutive en cycles gives locked=1 after the 4th edge.
- Reset mid-operation: returns to the reset values on that edge; no err pulse and no lap pulse.
- Counter reset upstream: the word jumps back to 8'b0000_0001. Outside the wrap from 8'b1000_0000 this is a mismatch (err=1), and the checker relocks after LOCK_CNT further transitions.
- Position decode: pos = index of the set bit, e.g. 8'b0001_0000 -> 4.

Test Plan:
- Clean run: reset 1 cycle, en=1, drive 01,02,04,...,80,01,02 -> locked=1 after the 4th word; pos tracks 0..7,0,1; lap=1 exactly on the 80->01 edge; err never asserts; err_count=0.
- Mid-stream jump: locked at word 08, then drive 01 -> err pulses 1 cycle, err_count=1, locked=0, pos=0. Then drive 02,04,08 -> locked=1 again.
- Illegal words: while locked, drive 8'b0000_0000, then 8'b0000_0011 -> one err pulse (first word) and err_count=1. pos holds its last legal value. The second word only keeps good=0 in SEARCH, with no second err.
- Enable gating: locked at 04, en=0 for 5 cycles with count set to garbage (8'hFF) -> no change to any output. en=1 with 08 -> stays locked, pos=3.
- Saturation: force 300 lock/error cycles with ERR_W=8 -> err_count stops at 255; err still pulses each time.
- Reset priority: assert reset together with en=1 and a mismatching word while locked -> next cycle all outputs are at reset values and err=0.
